deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Serial-to-parallel converter for the platform's converter data links. It receives a one-bit stream qualified by a bit strobe and a word-boundary sync, and assembles N-bit words.
- Completed words are presented on a one-entry valid/ready output register.
- It is the receive-side counterpart of the platform's N-bit shift-register serializer. With default settings the bit order matches that serializer: the first bit received is word bit 0.

Parameters:
- N, 8, word width in bits (N >= 2).
- MSB_FIRST, 0: 0 = first received bit lands in out[0]; 1 = first received bit lands in out[N-1].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- bit_en  input  1  bit strobe; in and sync are sampled only on cycles where bit_en=1.
- in  input  1  serial data bit.
- sync  input  1  word-start marker; when 1 with bit_en, the current bit is bit 0 of a new word.
- out  output  N  assembled word; holds its value while out_valid=1.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word; the transfer happens on the cycle where out_valid & out_ready.
- overflow  output  1  sticky: a completed word was dropped because the output register was full.
- frame_err  output  1  single-cycle pulse: sync arrived while a partial word was in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HUNT, count=0, shift=0.
  - out=0, out_valid=0, overflow=0, frame_err=0.
- frame_err defaults to 0 on every cycle; it is only pulsed as described below.
- States:
  - HUNT: discard every bit until a bit_en & sync cycle arrives.
    - That bit is stored as word bit 0, count=1, go to SHIFT.
  - SHIFT, on bit_en & ~sync:
    - Store the bit at position count (mirrored to N-1-count if MSB_FIRST=1); count++.
  - SHIFT, on bit_en & sync with count != 0:
    - Discard the partial word, pulse frame_err for one cycle.
    - Store the current bit as bit 0, count=1.
  - SHIFT, on bit_en & sync with count == 0:
    - Normal aligned word start; no error.
- Word completion: the cycle where the Nth bit is stored.
  - count wraps to 0 and the block stays in SHIFT. The next word is contiguous and needs no further sync.
  - The completed word (shift contents plus the current bit) is offered to the output register in that same cycle.
- Output register:
  - If out_valid=0, or out_valid=1 & out_ready=1 in the completion cycle: out <= word, out_valid <= 1. out_valid is high on the next cycle, so latency from the Nth bit_en cycle to out_valid is 1 clk.
  - Else (full, not draining): the word is dropped, overflow <= 1, out/out_valid unchanged.
  - out_valid & out_ready with no completion in that cycle: out_valid <= 0; out retains its old value.
- overflow clears only on reset.
- bit_en=0: no change to shift, count or state. The output handshake still operates.
- bit_en on consecutive cycles is legal: one bit is taken per cycle.
- Reset asserted mid-word discards the partial word and any held output word.
- Width rules:
  - count is ceil(log2 N) bits and wraps at N, not at a power of two.
  - No arithmetic on data.

Test Plan:
- Reset with reset=0 -> out=0, out_valid=0, overflow=0, state HUNT. Then send 5 bits with sync=0 -> out_valid stays 0.
- N=8, MSB_FIRST=0, sync on first bit, bits 1,0,1,1,0,0,1,0 on consecutive bit_en cycles -> out=8'h4D, out_valid=1 exactly one clk after the 8th bit_en cycle.
- Same stream with MSB_FIRST=1 -> out=8'hB2.
- Two contiguous words 8'h4D then 8'hA5, out_ready held 1, single sync at start -> two out_valid pulses carrying 4D then A5, overflow=0.
- out_ready=0 for 3 contiguous words -> first word 8'h4D held on out; words 2 and 3 dropped; overflow=1 after word 2 completes and stays 1 after out_ready rises.
- Sync asserted at bit 4 of a word -> frame_err pulses 1 cycle; the partial word is never output; the next 8 bits starting at the sync form a correct word.
- Word completion in the same cycle that out_ready=1 drains a held word -> new word loaded, out_valid stays 1, no overflow.

Source files
------------

// File: rtl/deserializer.sv
// Serial-to-parallel converter: assembles N-bit words from a strobed bit
// stream aligned by a word-start sync, and presents each completed word on a
// one-entry valid/ready output register with sticky overflow and a
// single-cycle frame error pulse.
module deserializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         in,
    input  logic         sync,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overflow,
    output logic         frame_err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [N-1:0]    shift;

    logic            take;
    logic            start;
    logic            complete;
    logic            misalign;
    logic [CW-1:0]   slot;
    logic [CW-1:0]   pos;
    logic [N-1:0]    word;

    // Decide whether this bit is taken, where it lands, and the resulting word.
    // A word start (HUNT sync, any sync, or aligned count 0) clears the
    // partially assembled contents so a resync never leaks stale bits.
    always_comb begin
        take     = bit_en && ((state == SHIFT) || sync);
        start    = (state == HUNT) || sync || (count == '0);
        slot     = start ? '0 : count;
        pos      = MSB_FIRST ? (LAST - slot) : slot;
        word     = start ? '0 : shift;
        word[pos] = in;
        complete = take && (slot == LAST);
        misalign = bit_en && (state == SHIFT) && sync && (count != '0);
    end

    // Bit assembly FSM plus the output holding register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            count     <= '0;
            shift     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= misalign;
            if (take) begin
                state <= SHIFT;
                shift <= word;
                count <= (slot == LAST) ? '0 : slot + CW'(1);
            end
            if (complete) begin
                if (!out_valid || out_ready) begin
                    out       <= word;
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer: two instances (LSB-first and
// MSB-first) share the same stimulus.
module tb_deserializer;

    logic       clk;
    logic       reset;
    logic       bit_en;
    logic       in;
    logic       sync;
    logic       out_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       overflow;
    logic       frame_err;
    logic [7:0] out_m;
    logic       out_valid_m;
    logic       overflow_m;
    logic       frame_err_m;

    int checks   = 0;
    int failures = 0;

    deserializer #(.N(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in(in), .sync(sync),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    deserializer #(.N(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in(in), .sync(sync),
        .out(out_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .overflow(overflow_m), .frame_err(frame_err_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic drive(input logic be, input logic b, input logic s, input logic rdy);
        @(negedge clk);
        bit_en    = be;
        in        = b;
        sync      = s;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_en = 1'b0; in = 1'b0; sync = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bit_en = 1'b0; in = 1'b0; sync = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: out=%h valid=%b required out=00 valid=0", out, out_valid);
        end
        checks++;
        if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: overflow=%b frame_err=%b required 0 0", overflow, frame_err);
        end
        @(negedge clk);
        reset = 1'b1;
        // No sync: eight bits are all discarded while hunting.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_valid_m !== 1'b0) begin
            failures++;
            $display("FAIL hunt_discard: valid=%b valid_m=%b required 0", out_valid, out_valid_m);
        end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'h4D;
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, w[i], i == 0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early: valid=%b required 0 after 7 bits", out_valid);
        end
        drive(1'b1, w[7], 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h4D) begin
            failures++;
            $display("FAIL basic_lsb: out=%h valid=%b required 4d 1", out, out_valid);
        end
        checks++;
        if (out_valid_m !== 1'b1 || out_m !== 8'hB2) begin
            failures++;
            $display("FAIL basic_msb: out=%h valid=%b required b2 1", out_m, out_valid_m);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out !== 8'h4D) begin
            failures++;
            $display("FAIL basic_drain: out=%h valid=%b required 4d 0", out, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h4D;
        b = 8'hA5;
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, a[i], i == 0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h4D) begin
            failures++;
            $display("FAIL b2b_first: out=%h valid=%b required 4d 1", out, out_valid);
        end
        drive(1'b1, b[0], 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: valid=%b required 0", out_valid);
        end
        for (int i = 1; i < 8; i++) drive(1'b1, b[i], 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'hA5 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: out=%h valid=%b ovf=%b required a5 1 0", out, out_valid, overflow);
        end
        checks++;
        if (out_m !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_second_msb: out=%h required a5", out_m);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        w = 8'h3C;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, w[i], i == 0, 1'b0);
            drive(1'b0, ~w[i], 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h3C || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL gaps: out=%h valid=%b ferr=%b required 3c 1 0", out, out_valid, frame_err);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] w [3];
        w[0] = 8'h4D; w[1] = 8'hA5; w[2] = 8'h3C;
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, w[0][i], i == 0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h4D || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_w1: out=%h valid=%b ovf=%b required 4d 1 0", out, out_valid, overflow);
        end
        for (int i = 0; i < 7; i++) drive(1'b1, w[1][i], 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_early: ovf=%b required 0 before word 2 completes", overflow);
        end
        drive(1'b1, w[1][7], 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || out !== 8'h4D || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_w2: out=%h valid=%b ovf=%b required 4d 1 1", out, out_valid, overflow);
        end
        for (int i = 0; i < 8; i++) drive(1'b1, w[2][i], 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || out !== 8'h4D) begin
            failures++;
            $display("FAIL ovf_w3: out=%h ovf=%b required 4d 1", out, overflow);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1 || out !== 8'h4D) begin
            failures++;
            $display("FAIL ovf_sticky: out=%h valid=%b ovf=%b required 4d 0 1", out, out_valid, overflow);
        end
        // Asynchronous reset mid-word clears everything without a clock edge.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, i == 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b0 || out !== 8'h00 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: out=%h valid=%b ovf=%b required 00 0 0", out, out_valid, overflow);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_frame_err();
        logic [7:0] w;
        w = 8'h4D;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i == 0, 1'b1);
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_quiet: frame_err=%b required 0", frame_err);
        end
        drive(1'b1, w[0], 1'b1, 1'b1);
        checks++;
        if (frame_err !== 1'b1 || frame_err_m !== 1'b1) begin
            failures++;
            $display("FAIL ferr_pulse: frame_err=%b msb=%b required 1", frame_err, frame_err_m);
        end
        drive(1'b1, w[1], 1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_single: frame_err=%b required 0", frame_err);
        end
        for (int i = 2; i < 7; i++) drive(1'b1, w[i], 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ferr_partial: valid=%b required 0", out_valid);
        end
        drive(1'b1, w[7], 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h4D || out_m !== 8'hB2) begin
            failures++;
            $display("FAIL ferr_word: out=%h out_m=%h valid=%b required 4d b2 1", out, out_m, out_valid);
        end
    endtask

    task automatic test_drain_complete();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h4D;
        b = 8'hA5;
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, a[i], i == 0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, b[i], 1'b0, 1'b0);
        checks++;
        if (out !== 8'h4D || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_held: out=%h valid=%b required 4d 1", out, out_valid);
        end
        drive(1'b1, b[7], 1'b0, 1'b1);
        checks++;
        if (out !== 8'hA5 || out_valid !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL drain_load: out=%h valid=%b ovf=%b required a5 1 0", out, out_valid, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_frame_err();
        test_drain_complete();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
